// File: rtl/leds_racer_pkg.sv
// Shared types and default line timing for the leds_line transmitter and decoder.
package leds_racer_pkg;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2
  } dec_state_e;

  localparam int GRB_W = 24;

  // 50 MHz defaults: bit 0 high ~20 clk, bit 1 high ~40 clk, 62 clk per bit.
  localparam int DEF_MAX_POS           = 109;
  localparam int DEF_BIT_THRESHOLD_CLK = 30;
  localparam int DEF_RESET_CLK_CNT     = 2500;
  localparam int T0H_CLK               = 20;
  localparam int T1H_CLK               = 40;
  localparam int BIT_PERIOD_CLK        = 62;

endpackage

// File: rtl/leds_line_sync.sv
// Two-flop synchronizer for an asynchronous level input, with rise/fall detect
// on the synchronized level.
module leds_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      line_s <= 1'b0;
      line_q <= 1'b0;
    end else begin
      meta   <= raw;
      line_s <= meta;
      line_q <= line_s;
    end
  end

  assign rise = line_s & ~line_q;
  assign fall = line_q & ~line_s;

endmodule

// File: rtl/leds_line_decoder.sv
// WS2812-style line decoder: measures high pulses into bits, packs GRB pixels,
// and flags latch gaps and protocol errors.
module leds_line_decoder
  import leds_racer_pkg::*;
#(
  parameter int MAX_POS           = DEF_MAX_POS,
  parameter int BIT_THRESHOLD_CLK = DEF_BIT_THRESHOLD_CLK,
  parameter int RESET_CLK_CNT     = DEF_RESET_CLK_CNT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       leds_line,
  output logic                       pixel_valid,
  output logic [GRB_W-1:0]           pixel_grb,
  output logic [$clog2(MAX_POS)-1:0] pixel_index,
  output logic                       frame_done,
  output logic                       frame_error
);

  localparam int CNT_W = $clog2(RESET_CLK_CNT + 1);
  localparam int IDX_W = $clog2(MAX_POS + 1);
  localparam int OUT_W = $clog2(MAX_POS);
  localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(RESET_CLK_CNT);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(BIT_THRESHOLD_CLK);
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(MAX_POS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == GAP_CNT) ? c : c + CNT_W'(1);
  endfunction

  logic line_s, rise, fall;

  leds_line_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (leds_line),
    .line_s (line_s),
    .rise   (rise),
    .fall   (fall)
  );

  dec_state_e         state_q, state_d;
  logic [CNT_W-1:0]   low_cnt, low_cnt_d, high_cnt, high_cnt_d;
  logic [4:0]         bit_cnt, bit_cnt_d;
  logic [GRB_W-2:0]   shreg, shreg_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               ovf, ovf_d, got_bit, got_bit_d;
  logic               pixel_valid_d, frame_done_d, frame_error_d;
  logic [GRB_W-1:0]   pixel_grb_d;
  logic [OUT_W-1:0]   pixel_index_d;
  logic               bit_val;
  logic [GRB_W-1:0]   word;

  always_comb begin
    state_d       = state_q;
    low_cnt_d     = low_cnt;
    high_cnt_d    = high_cnt;
    bit_cnt_d     = bit_cnt;
    shreg_d       = shreg;
    idx_d         = idx;
    ovf_d         = ovf;
    got_bit_d     = got_bit;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    pixel_grb_d   = pixel_grb;
    pixel_index_d = pixel_index;
    bit_val       = (high_cnt >= ONE_CNT);
    word          = {shreg, bit_val};

    unique case (state_q)
      WAIT_GAP: begin
        if (line_s) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = sat_inc(low_cnt);
          if (low_cnt_d == GAP_CNT) state_d = IDLE;
        end
      end
      IDLE: begin
        if (rise) begin
          high_cnt_d = CNT_W'(1);
          state_d    = HIGH;
        end else if (low_cnt != GAP_CNT) begin
          low_cnt_d = sat_inc(low_cnt);
        end else begin
          // Idempotent once the flags are cleared, so holding here never re-pulses.
          frame_done_d  = got_bit;
          frame_error_d = (bit_cnt != 5'd0);
          idx_d         = '0;
          bit_cnt_d     = '0;
          ovf_d         = 1'b0;
          got_bit_d     = 1'b0;
        end
      end
      HIGH: begin
        if (fall) begin
          shreg_d   = word[GRB_W-2:0];
          got_bit_d = 1'b1;
          low_cnt_d = CNT_W'(1);
          state_d   = IDLE;
          if (bit_cnt == 5'(GRB_W - 1)) begin
            bit_cnt_d = '0;
            if (idx < IDX_LIMIT) begin
              pixel_valid_d = 1'b1;
              pixel_grb_d   = word;
              pixel_index_d = idx[OUT_W-1:0];
              idx_d         = idx + IDX_W'(1);
            end else if (!ovf) begin
              ovf_d         = 1'b1;
              frame_error_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end else begin
          high_cnt_d = sat_inc(high_cnt);
          if (high_cnt_d == GAP_CNT) begin
            // Stuck-high line: abandon the frame and resynchronise on a fresh gap.
            frame_error_d = 1'b1;
            state_d       = WAIT_GAP;
            bit_cnt_d     = '0;
            idx_d         = '0;
            ovf_d         = 1'b0;
            got_bit_d     = 1'b0;
            low_cnt_d     = '0;
            high_cnt_d    = '0;
          end
        end
      end
      default: state_d = WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_GAP;
      low_cnt     <= '0;
      high_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      idx         <= '0;
      ovf         <= 1'b0;
      got_bit     <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      pixel_grb   <= '0;
      pixel_index <= '0;
    end else begin
      state_q     <= state_d;
      low_cnt     <= low_cnt_d;
      high_cnt    <= high_cnt_d;
      bit_cnt     <= bit_cnt_d;
      shreg       <= shreg_d;
      idx         <= idx_d;
      ovf         <= ovf_d;
      got_bit     <= got_bit_d;
      pixel_valid <= pixel_valid_d;
      frame_done  <= frame_done_d;
      frame_error <= frame_error_d;
      pixel_grb   <= pixel_grb_d;
      pixel_index <= pixel_index_d;
    end
  end

endmodule
